sdpmem_clr: RTL and testbench
=============================

# sdpmem_clr

Simple dual-port RAM with one write port (A) and one read port (B) on a single clock. Write port A has per-byte write enables. Read port B is registered and carries a valid flag. A built-in clear engine fills the whole array with `CLEAR_VALUE` after reset and on request. It is the parametrised successor of the team's simple dual-port memory, used wherever buffers must start from a known state (packet buffers, lookup tables, descriptor rings).

## Interface
Parameters:
- `DEPTH`, 6: address width; the array holds 2^DEPTH words.
- `WIDTH`, 32: data width. Must be a multiple of 8. NB = WIDTH/8 byte lanes.
- `CLEAR_VALUE`, 0: WIDTH-bit word written to every location by the clear engine.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `clr` in 1: clear request, sampled only in IDLE.
- `busy` out 1: high while the clear engine owns the array.
- `ena` in 1: port A enable.
- `wea` in NB: byte write enables; bit i covers `dia[8i+7:8i]`.
- `addra` in DEPTH: write address.
- `dia` in WIDTH: write data.
- `enb` in 1: port B read enable.
- `addrb` in DEPTH: read address.
- `dob` out WIDTH: read data.
- `dob_valid` out 1: `dob` holds data from an accepted read.

## Operation
- FSM states:
  - CLEAR: counter `cnt` (DEPTH bits) writes `CLEAR_VALUE` to `mem[cnt]`, one word per cycle, then increments. When `cnt` = 2^DEPTH−1, that word is written and the FSM goes to IDLE. `cnt` wraps to 0.
  - IDLE: normal operation. `clr`=1 moves the FSM to CLEAR with `cnt`=0.
- Reset: asynchronous assertion forces CLEAR with `cnt`=0, `busy`=1, `dob`=0 and `dob_valid`=0. Array contents are not reset; the clear engine covers them. Reset asserted mid-clear restarts the clear from address 0.
- While `busy`=1:
  - Port A writes are dropped.
  - `enb` is ignored, `dob_valid`=0 and `dob` holds its value.
  - `clr` is ignored.
- Port A in IDLE: on the rising edge with `ena`=1, each lane i with `wea[i]`=1 updates the corresponding byte of `mem[addra]`. Other lanes keep their value. `wea`=0 with `ena`=1 is a no-op.
- Port B in IDLE: `enb`=1 captures `mem[addrb]` into `dob` at the edge and sets `dob_valid`=1. `enb`=0 clears `dob_valid` and `dob` holds its value.
- Read-during-write to the same address is read-first: `dob` gets the pre-write word.
- A `clr` edge in IDLE takes priority over a simultaneous port A write: the write is dropped.
- A read accepted on the same edge as `clr` still completes (`dob_valid`=1 next cycle). No further reads are accepted until `busy` falls.

## Timing
- Clear duration: exactly 2^DEPTH rising edges after `rst_n` release or after the `clr` edge.
- `busy` drops on the edge that writes address 2^DEPTH−1. Port A and port B are usable on the following edge.
- Read latency: 1 cycle (`dob`/`dob_valid` are valid after the edge that sampled `enb`).
- Write-to-read: a read on the edge after a write returns the new data.
- Throughput: one write and one read every cycle, independent addresses.

## Configuration
- `SDPMEM_CLR_OUTREG_EN` defined:
  - Adds a second output register stage; read latency is 2 cycles.
  - `dob_valid` is pipelined alongside `dob`; both registers reset to 0.
  - A read in flight when `clr` is taken still emerges 2 cycles after its issue.
- Undefined: single output register, latency 1.

## Test plan
(DEPTH=6, WIDTH=32, CLEAR_VALUE=32'hDEADBEEF, no macro unless stated)
- Release `rst_n`, hold `enb`=1 with `addrb`=5 -> `busy`=1 for exactly 64 cycles and `dob_valid`=0 throughout. On the first edge after `busy` falls, `dob`=32'hDEADBEEF and `dob_valid`=1.
- After clear, write 32'h11223344 to address 1 and 32'h55667788 to address 2 (`wea`=4'hF), then read address 2 -> `dob`=32'h55667788 one cycle later; reading address 1 -> 32'h11223344.
- Write 32'hAABBCCDD to address 1 with `wea`=4'b0011 -> read of address 1 returns 32'h1122CCDD.
- Write 32'h0 to address 2 with `enb`=1 and `addrb`=2 on the same edge -> `dob`=32'h55667788 (old data); the next read returns 32'h0.
- Pulse `clr` in IDLE with a simultaneous write of 32'h12345678 to address 3 -> `busy`=1 for 64 cycles; address 3 then reads 32'hDEADBEEF. Assert `rst_n` at clear cycle 20 -> the clear restarts and `busy` lasts 64 cycles from release.
- Define `SDPMEM_CLR_OUTREG_EN`, read address 2 after the second scenario's writes -> `dob`=32'h55667788 and `dob_valid`=1 exactly 2 cycles after `enb`.

Source files
------------

// File: rtl/sdpmem_clr.sv
// sdpmem_clr: simple dual-port RAM with byte write enables, registered read port and self-clear engine.
// Define SDPMEM_CLR_OUTREG_EN to add a second output register stage (read latency 2).
module sdpmem_clr #(
  parameter int               DEPTH       = 6,
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  output logic                 busy,
  input  logic                 ena,
  input  logic [WIDTH/8-1:0]   wea,
  input  logic [DEPTH-1:0]     addra,
  input  logic [WIDTH-1:0]     dia,
  input  logic                 enb,
  input  logic [DEPTH-1:0]     addrb,
  output logic [WIDTH-1:0]     dob,
  output logic                 dob_valid
);
  localparam int NB = WIDTH / 8;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t           r_state, w_state_nx;
  logic [DEPTH-1:0] r_cnt, w_cnt_nx;
  logic [WIDTH-1:0] r_mem [2**DEPTH];
  logic [WIDTH-1:0] r_dob;
  logic             r_dob_valid;
  logic             w_idle, w_wr, w_rd;
  assign w_idle = (r_state == IDLE);
  assign busy   = ~w_idle;
  // A clear request wins over a same-edge write; a same-edge read still completes.
  assign w_wr   = w_idle & ena & ~clr;
  assign w_rd   = w_idle & enb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (r_state == CLEAR) begin
      w_cnt_nx   = r_cnt + 1'b1;
      w_state_nx = (&r_cnt) ? IDLE : CLEAR;
    end else if (clr) begin
      w_cnt_nx   = '0;
      w_state_nx = CLEAR;
    end
  end
  always_ff @(posedge clk) begin
    if (busy)
      r_mem[r_cnt] <= CLEAR_VALUE;
    else if (w_wr)
      for (int i = 0; i < NB; i++)
        if (wea[i]) r_mem[addra][8*i +: 8] <= dia[8*i +: 8];
  end
  // Read-first: the array read sees the word before any same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dob       <= '0;
      r_dob_valid <= 1'b0;
    end else begin
      r_dob_valid <= w_rd;
      if (w_rd) r_dob <= r_mem[addrb];
    end
  end
`ifdef SDPMEM_CLR_OUTREG_EN
  logic [WIDTH-1:0] r_dob2;
  logic             r_dob_valid2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dob2       <= '0;
      r_dob_valid2 <= 1'b0;
    end else begin
      r_dob2       <= r_dob;
      r_dob_valid2 <= r_dob_valid;
    end
  end
  assign dob       = r_dob2;
  assign dob_valid = r_dob_valid2;
`else
  assign dob       = r_dob;
  assign dob_valid = r_dob_valid;
`endif
endmodule

// File: tb/tb_sdpmem_clr.sv
// tb_sdpmem_clr: directed self-checking bench for sdpmem_clr (DEPTH=6, WIDTH=32, CLEAR_VALUE=DEADBEEF).
module tb_sdpmem_clr;
  logic        clk = 1'b0;
  logic        rst_n, clr, busy, ena, enb, dob_valid;
  logic [3:0]  wea;
  logic [5:0]  addra, addrb;
  logic [31:0] dia, dob;
  int checks = 0;
  int errors = 0;
  sdpmem_clr #(.DEPTH(6), .WIDTH(32), .CLEAR_VALUE(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy), .ena(ena), .wea(wea),
    .addra(addra), .dia(dia), .enb(enb), .addrb(addrb), .dob(dob), .dob_valid(dob_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    ena = 1'b0; wea = 4'h0; enb = 1'b0; clr = 1'b0;
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] we);
    ena = 1'b1; wea = we; addra = a; dia = d;
    tick();
    idle();
  endtask
  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    enb = 1'b1; addrb = a;
    tick();
    idle();
`ifdef SDPMEM_CLR_OUTREG_EN
    tick();
`endif
    chk({tag, "_dob"}, dob, exp);
    chk({tag, "_valid"}, {31'd0, dob_valid}, 32'd1);
  endtask
  task automatic busy_run(input string tag, input int first);
    for (int i = first; i <= 64; i++) begin
      tick();
      chk(tag, {31'd0, busy}, {31'd0, (i < 64)});
      chk({tag, "_valid"}, {31'd0, dob_valid}, 32'd0);
    end
  endtask
  initial begin
    rst_n = 1'b0; idle(); addra = '0; addrb = 6'd5; dia = '0;
    enb = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_dob", dob, 32'd0);
    chk("rst_valid", {31'd0, dob_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_run("init_busy", 1);
    tick();
`ifdef SDPMEM_CLR_OUTREG_EN
    tick();
`endif
    chk("first_rd_dob", dob, 32'hDEADBEEF);
    chk("first_rd_valid", {31'd0, dob_valid}, 32'd1);
    idle();
    tick();
`ifdef SDPMEM_CLR_OUTREG_EN
    tick();
`endif
    wr(6'd1, 32'h11223344, 4'hF);
    wr(6'd2, 32'h55667788, 4'hF);
    rd("rd_a2", 6'd2, 32'h55667788);
    rd("rd_a1", 6'd1, 32'h11223344);
    tick();
`ifdef SDPMEM_CLR_OUTREG_EN
    tick();
`endif
    chk("hold_dob", dob, 32'h11223344);
    chk("idle_valid", {31'd0, dob_valid}, 32'd0);
    wr(6'd1, 32'hAABBCCDD, 4'b0011);
    rd("rd_partial", 6'd1, 32'h1122CCDD);
    wr(6'd1, 32'hFFFFFFFF, 4'h0);
    rd("rd_we0", 6'd1, 32'h1122CCDD);
    ena = 1'b1; wea = 4'hF; addra = 6'd2; dia = 32'h0; enb = 1'b1; addrb = 6'd2;
    tick();
    ena = 1'b0; wea = 4'h0;
`ifdef SDPMEM_CLR_OUTREG_EN
    tick();
    chk("rdw_old", dob, 32'h55667788);
    chk("rdw_new", {31'd0, dob_valid}, 32'd1);
    tick();
    chk("rdw_next", dob, 32'h0);
`else
    chk("rdw_old", dob, 32'h55667788);
    tick();
    chk("rdw_next", dob, 32'h0);
`endif
    idle();
    tick();
`ifdef SDPMEM_CLR_OUTREG_EN
    tick();
`endif
    clr = 1'b1; ena = 1'b1; wea = 4'hF; addra = 6'd3; dia = 32'h12345678; enb = 1'b1; addrb = 6'd1;
    tick();
    idle();
    chk("clr_busy", {31'd0, busy}, 32'd1);
`ifdef SDPMEM_CLR_OUTREG_EN
    tick();
    chk("clr_rd_dob", dob, 32'h1122CCDD);
    chk("clr_rd_valid", {31'd0, dob_valid}, 32'd1);
    busy_run("clr_busy_run", 2);
`else
    chk("clr_rd_dob", dob, 32'h1122CCDD);
    chk("clr_rd_valid", {31'd0, dob_valid}, 32'd1);
    busy_run("clr_busy_run", 1);
`endif
    rd("rd_a3_cleared", 6'd3, 32'hDEADBEEF);
    rd("rd_a1_cleared", 6'd1, 32'hDEADBEEF);
    clr = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 20; i++) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_dob", dob, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_run("restart_busy", 1);
    rd("rd_a2_restart", 6'd2, 32'hDEADBEEF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
